// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-control field positions
// and the parity helper used by both the receive and transmit paths.
package uart_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_WAITHIGH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_START    = ST_START,
    S_DATA     = ST_DATA,
    S_PARITY   = ST_PARITY,
    S_STOP     = ST_STOP,
    S_WAITHIGH = ST_WAITHIGH
  } uart_rx_state_e;

  localparam int CFG_LEN_LO  = 0;
  localparam int CFG_LEN_HI  = 1;
  localparam int CFG_STOP2   = 2;
  localparam int CFG_PAR_EN  = 3;
  localparam int CFG_EVEN    = 4;
  localparam int CFG_STICK   = 5;

  // Expected parity bit for a character; bits above the configured width are ignored.
  function automatic logic uart_parity(input logic [7:0] data, input logic [5:0] cfg);
    logic [7:0] mask;
    logic       res;
    mask = 8'hFF >> (2'd3 - cfg[CFG_LEN_HI:CFG_LEN_LO]);
    if (cfg[CFG_STICK]) begin
      res = ~cfg[CFG_EVEN];
    end else begin
      res = ~(^(data & mask) ^ cfg[CFG_EVEN]);
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the pad signal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled de-framing of start, 5-8 data, optional parity
// and stop bits, writing each character plus status flags into the RX FIFO.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       baudRateX16tick,
  input  logic [6:0] controlReg,
  input  logic       uartRxLine,
  input  logic       fifoFull,
  output logic [7:0] fifoData,
  output logic       fifoWe,
  output logic       parityError,
  output logic       frameError,
  output logic       breakDetected,
  output logic       overrunError,
  output logic       busy
);

  logic           rx_s;
  logic           unused_cfg_s;
  uart_rx_state_e state_q, state_d;
  logic [3:0]     tick_cnt_q, tick_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [5:0]     cfg_q, cfg_d;
  logic [7:0]     shift_q, shift_d;
  logic           prev_q, prev_d;
  logic           par_err_q, par_err_d;
  logic           any_one_q, any_one_d;
  logic           pend_q, pend_d;
  logic [7:0]     pend_data_q, pend_data_d;
  logic           pend_pe_q, pend_pe_d;
  logic           pend_fe_q, pend_fe_d;
  logic           pend_brk_q, pend_brk_d;
  logic [7:0]     data_q, data_d;
  logic           we_q, we_d;
  logic           pe_q, pe_d;
  logic           fe_q, fe_d;
  logic           brk_q, brk_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;
  logic [2:0]     last_bit_s;

  assign unused_cfg_s = controlReg[6];
  assign last_bit_s   = {1'b0, cfg_q[CFG_LEN_HI:CFG_LEN_LO]} + 3'd4;

  uart_rx_sync u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .async_i(uartRxLine),
    .sync_o (rx_s)
  );

  // Frame FSM: every sampling decision happens on a baud tick.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_d       = cfg_q;
    shift_d     = shift_q;
    prev_d      = prev_q;
    par_err_d   = par_err_q;
    any_one_d   = any_one_q;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    pend_pe_d   = pend_pe_q;
    pend_fe_d   = pend_fe_q;
    pend_brk_d  = pend_brk_q;
    if (baudRateX16tick) begin
      prev_d     = rx_s;
      tick_cnt_d = tick_cnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          tick_cnt_d = 4'd0;
          if (!rx_s && prev_q) begin
            state_d   = S_START;
            cfg_d     = controlReg[5:0];
            shift_d   = 8'h00;
            bit_cnt_d = 3'd0;
            par_err_d = 1'b0;
            any_one_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            state_d = S_START;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == 4'd15) begin
            shift_d[bit_cnt_q] = rx_s;
            any_one_d          = any_one_q | rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == last_bit_s) begin
              state_d = cfg_q[CFG_PAR_EN] ? S_PARITY : S_STOP;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          if (tick_cnt_q == 4'd15) begin
            par_err_d = (rx_s != uart_parity(shift_q, cfg_q));
            any_one_d = any_one_q | rx_s;
            state_d   = S_STOP;
          end else begin
            state_d = S_PARITY;
          end
        end
        S_STOP: begin
          if (tick_cnt_q == 4'd15) begin
            pend_d      = 1'b1;
            pend_data_d = shift_q;
            pend_pe_d   = par_err_q;
            pend_fe_d   = ~rx_s;
            pend_brk_d  = ~any_one_q & ~rx_s;
            state_d     = rx_s ? S_IDLE : S_WAITHIGH;
          end else begin
            state_d = S_STOP;
          end
        end
        S_WAITHIGH: begin
          state_d = rx_s ? S_IDLE : S_WAITHIGH;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      pend_d = 1'b0;
    end
  end

  // FIFO write / overrun one cycle after the stop sample; status holds until the next write.
  always_comb begin
    data_d = data_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    brk_d  = brk_q;
    we_d   = 1'b0;
    ovr_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    if (pend_q) begin
      if (!fifoFull) begin
        we_d   = 1'b1;
        data_d = pend_data_q;
        pe_d   = pend_pe_q;
        fe_d   = pend_fe_q;
        brk_d  = pend_brk_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      cfg_q       <= 6'd0;
      shift_q     <= 8'h00;
      prev_q      <= 1'b1;
      par_err_q   <= 1'b0;
      any_one_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      pend_pe_q   <= 1'b0;
      pend_fe_q   <= 1'b0;
      pend_brk_q  <= 1'b0;
      data_q      <= 8'h00;
      we_q        <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      brk_q       <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_q       <= cfg_d;
      shift_q     <= shift_d;
      prev_q      <= prev_d;
      par_err_q   <= par_err_d;
      any_one_q   <= any_one_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_pe_q   <= pend_pe_d;
      pend_fe_q   <= pend_fe_d;
      pend_brk_q  <= pend_brk_d;
      data_q      <= data_d;
      we_q        <= we_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      brk_q       <= brk_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign fifoData      = data_q;
  assign fifoWe        = we_q;
  assign parityError   = pe_q;
  assign frameError    = fe_q;
  assign breakDetected = brk_q;
  assign overrunError  = ovr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit at 64 clocks per bit
// (tick every 4 clocks), results captured on each write strobe.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic [6:0] ctrl;
  logic       line;
  logic       full;
  logic [7:0] fifo_data;
  logic       fifo_we;
  logic       par_err;
  logic       frm_err;
  logic       brk;
  logic       ovr;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         we_cnt = 0;
  int         ovr_cycles = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;
  logic       cap_brk = 1'b0;

  uart_rx dut (
    .clock          (clock),
    .reset          (reset),
    .baudRateX16tick(tick),
    .controlReg     (ctrl),
    .uartRxLine     (line),
    .fifoFull       (full),
    .fifoData       (fifo_data),
    .fifoWe         (fifo_we),
    .parityError    (par_err),
    .frameError     (frm_err),
    .breakDetected  (brk),
    .overrunError   (ovr),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #1 tick = 1'b1;
      @(posedge clock);
      #1 tick = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (fifo_we) begin
      we_cnt   = we_cnt + 1;
      cap_data = fifo_data;
      cap_pe   = par_err;
      cap_fe   = frm_err;
      cap_brk  = brk;
    end
    if (ovr) begin
      ovr_cycles = ovr_cycles + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(d[i]);
    end
    if (par_en) begin
      drive_bit(par_b);
    end
    drive_bit(stop_b);
  endtask

  task automatic expect_write(input string tag, input int we_before, input logic [7:0] d,
                              input logic pe, input logic fe, input logic bk);
    check_val({tag, "_we_count"}, we_cnt, we_before + 1);
    check_val({tag, "_data"}, cap_data, d);
    check_val({tag, "_parity"}, cap_pe, pe);
    check_val({tag, "_frame"}, cap_fe, fe);
    check_val({tag, "_break"}, cap_brk, bk);
  endtask

  initial begin
    int w0;
    int o0;
    reset = 1'b0;
    ctrl  = 7'h03;
    line  = 1'b1;
    full  = 1'b0;
    wait_clks(5);
    check_val("rst_data", fifo_data, 8'h00);
    check_val("rst_we", fifo_we, 1'b0);
    check_val("rst_flags", {par_err, frm_err, brk, ovr}, 4'h0);
    check_val("rst_busy", busy, 1'b0);
    reset = 1'b1;
    wait_clks(20);

    // 8N1, 0xA5
    w0 = we_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check_val("a5_busy_after_stop", busy, 1'b0);
    idle(64);
    expect_write("a5", w0, 8'hA5, 1'b0, 1'b0, 1'b0);

    // 5 data bits, odd parity: 0x1F has five ones, correct parity bit is 0
    ctrl = 7'h08;
    w0 = we_cnt;
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    idle(64);
    expect_write("p5_ok", w0, 8'h1F, 1'b0, 1'b0, 1'b0);
    w0 = we_cnt;
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
    idle(64);
    expect_write("p5_bad", w0, 8'h1F, 1'b1, 1'b0, 1'b0);

    // 7 data bits, stick parity with even select: expected parity bit 0
    ctrl = 7'h3A;
    w0 = we_cnt;
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
    idle(64);
    expect_write("stick", w0, 8'h55, 1'b0, 1'b0, 1'b0);

    // 5-tick low glitch: false start, no write
    ctrl = 7'h03;
    w0 = we_cnt;
    line = 1'b0;
    wait_clks(20);
    idle(200);
    check_val("glitch_we_count", we_cnt, w0);
    check_val("glitch_busy", busy, 1'b0);

    // 8N1 with stop bit 0, line held low afterwards
    w0 = we_cnt;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
    wait_clks(3 * BIT_CLKS);
    expect_write("stop0", w0, 8'h81, 1'b0, 1'b1, 1'b0);
    check_val("stop0_busy_low_line", busy, 1'b1);
    idle(128);
    check_val("stop0_no_new_frame", we_cnt, w0 + 1);
    check_val("stop0_busy_after_high", busy, 1'b0);

    // Break with 8E1: line low for two frame times
    ctrl = 7'h1B;
    w0 = we_cnt;
    line = 1'b0;
    wait_clks(2 * 11 * BIT_CLKS);
    idle(128);
    expect_write("break", w0, 8'h00, 1'b0, 1'b1, 1'b1);
    w0 = we_cnt;
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1);
    idle(64);
    expect_write("after_break", w0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // FIFO full: overrun pulse only, held outputs unchanged
    ctrl = 7'h03;
    full = 1'b1;
    w0 = we_cnt;
    o0 = ovr_cycles;
    send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1);
    idle(64);
    full = 1'b0;
    check_val("ovr_we_count", we_cnt, w0);
    check_val("ovr_cycles", ovr_cycles, o0 + 1);
    check_val("ovr_data_held", fifo_data, 8'h3C);

    // Reset in the middle of the data bits
    w0 = we_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check_val("mid_busy", busy, 1'b1);
    reset = 1'b0;
    line  = 1'b1;
    wait_clks(4);
    check_val("midrst_data", fifo_data, 8'h00);
    check_val("midrst_flags", {par_err, frm_err, brk, ovr, fifo_we}, 5'h00);
    check_val("midrst_busy", busy, 1'b0);
    reset = 1'b1;
    idle(600);
    check_val("midrst_no_write", we_cnt, w0);

    // Recovery frame after reset
    w0 = we_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    idle(64);
    expect_write("recover", w0, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
